// File: rtl/troop_unit.sv
// Troop unit: deploys at a position, marches toward a target, engages with a
// periodic attack handshake, takes per-frame damage and dies at zero hit points.
module troop_unit #(
   parameter int HP_MAX     = 20,
   parameter int SPEED      = 2,
   parameter int MOVE_DIV   = 2,
   parameter int ATK_PERIOD = 60,
   parameter int NUM_SRC    = 5,
   parameter int DMG_W      = 3,
   parameter int TOL_X      = 6,
   parameter int TOL_Y      = 2
) (
   input  logic                        Clk,
   input  logic                        reset,
   input  logic                        frame_tick,
   input  logic                        idle,
   input  logic                        deploy_req,
   input  logic [9:0]                  deploy_x,
   input  logic [9:0]                  deploy_y,
   input  logic [9:0]                  target_x,
   input  logic [9:0]                  target_y,
   input  logic [2:0]                  target_index,
   input  logic [NUM_SRC*DMG_W-1:0]    dmg_in,
   input  logic                        attack_ack,
   output logic [9:0]                  pos_x,
   output logic [9:0]                  pos_y,
   output logic [$clog2(HP_MAX+1)-1:0] hp,
   output logic [1:0]                  state,
   output logic                        attack_valid,
   output logic [2:0]                  attack_index
);
   localparam int HPW  = $clog2(HP_MAX + 1);
   localparam int SUMW = DMG_W + $clog2(NUM_SRC);
   localparam int CMPW = ((SUMW > HPW) ? SUMW : HPW) + 1;
   localparam int CNTW = $clog2(ATK_PERIOD + 1);
   localparam int DIVW = $clog2(MOVE_DIV + 1);

   localparam logic [9:0]      SPD      = 10'(SPEED);
   localparam logic [9:0]      TX       = 10'(TOL_X);
   localparam logic [9:0]      TY       = 10'(TOL_Y);
   localparam logic [HPW-1:0]  HP_FULL  = HPW'(HP_MAX);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ATK_PERIOD - 1);
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(MOVE_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_MARCH  = 2'd1,
      S_ENGAGE = 2'd2,
      S_DEAD   = 2'd3
   } state_t;

   state_t          r_state;
   logic [9:0]      r_pos_x;
   logic [9:0]      r_pos_y;
   logic [HPW-1:0]  r_hp;
   logic [CNTW-1:0] r_cnt;
   logic [DIVW-1:0] r_div;
   logic            r_av;
   logic [2:0]      r_idx;

   logic [SUMW-1:0] w_dmg_sum;
   logic [CMPW-1:0] w_hp_ext;
   logic [CMPW-1:0] w_sum_ext;
   logic            w_lethal;
   logic [HPW-1:0]  w_hp_next;
   logic            w_step;
   logic [9:0]      w_mx;
   logic [9:0]      w_my;
   logic            w_tol_next;
   logic            w_tol_cur;
   logic            w_ack;

   function automatic logic [9:0] absdiff(input logic [9:0] a, input logic [9:0] b);
      if (a >= b) begin
         absdiff = a - b;
      end else begin
         absdiff = b - a;
      end
   endfunction

   // Moves one axis toward the target; the target is reached exactly rather than overshot.
   function automatic logic [9:0] step_axis(input logic [9:0] p, input logic [9:0] t);
      if (absdiff(p, t) <= SPD) begin
         step_axis = t;
      end else if (t > p) begin
         step_axis = p + SPD;
      end else begin
         step_axis = p - SPD;
      end
   endfunction

   // Damage sum and saturating hit-point update, compared in a common wide width.
   always_comb begin
      w_dmg_sum = {SUMW{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         w_dmg_sum = w_dmg_sum + SUMW'(dmg_in[i*DMG_W +: DMG_W]);
      end
      w_hp_ext  = CMPW'(r_hp);
      w_sum_ext = CMPW'(w_dmg_sum);
      w_lethal  = (w_sum_ext >= w_hp_ext);
      if (w_lethal) begin
         w_hp_next = {HPW{1'b0}};
      end else begin
         w_hp_next = HPW'(w_hp_ext - w_sum_ext);
      end
   end

   // Candidate position for this tick and the engage-window tests.
   always_comb begin
      w_step = (r_div == DIV_LAST);
      if (w_step) begin
         w_mx = step_axis(r_pos_x, target_x);
         w_my = step_axis(r_pos_y, target_y);
      end else begin
         w_mx = r_pos_x;
         w_my = r_pos_y;
      end
      w_tol_next = (absdiff(w_mx, target_x) <= TX) && (absdiff(w_my, target_y) <= TY);
      w_tol_cur  = (absdiff(r_pos_x, target_x) <= TX) && (absdiff(r_pos_y, target_y) <= TY);
      w_ack      = r_av & attack_ack;
   end

   // Unit state machine; the attack handshake completes on any cycle, the rest on frame ticks.
   always_ff @(posedge Clk) begin
      if (reset || idle) begin
         r_state <= S_IDLE;
         r_pos_x <= 10'd0;
         r_pos_y <= 10'd0;
         r_hp    <= {HPW{1'b0}};
         r_cnt   <= {CNTW{1'b0}};
         r_div   <= {DIVW{1'b0}};
         r_av    <= 1'b0;
         r_idx   <= 3'd0;
      end else begin
         if (w_ack) begin
            r_av  <= 1'b0;
            r_cnt <= {CNTW{1'b0}};
         end
         if (frame_tick) begin
            case (r_state)
               S_IDLE: begin
                  if (deploy_req) begin
                     r_pos_x <= deploy_x;
                     r_pos_y <= deploy_y;
                     r_hp    <= HP_FULL;
                     r_cnt   <= {CNTW{1'b0}};
                     r_div   <= {DIVW{1'b0}};
                     r_av    <= 1'b0;
                     r_state <= S_MARCH;
                  end
               end
               S_MARCH: begin
                  if (w_lethal) begin
                     r_hp    <= {HPW{1'b0}};
                     r_av    <= 1'b0;
                     r_state <= S_DEAD;
                  end else begin
                     r_hp    <= w_hp_next;
                     r_pos_x <= w_mx;
                     r_pos_y <= w_my;
                     r_div   <= w_step ? {DIVW{1'b0}} : r_div + 1'b1;
                     if (w_tol_next) begin
                        r_cnt   <= {CNTW{1'b0}};
                        r_state <= S_ENGAGE;
                     end
                  end
               end
               S_ENGAGE: begin
                  if (w_lethal) begin
                     r_hp    <= {HPW{1'b0}};
                     r_av    <= 1'b0;
                     r_state <= S_DEAD;
                  end else begin
                     r_hp <= w_hp_next;
                     if (!w_tol_cur) begin
                        r_cnt   <= {CNTW{1'b0}};
                        r_div   <= {DIVW{1'b0}};
                        r_av    <= 1'b0;
                        r_state <= S_MARCH;
                     end else if (!w_ack && !r_av) begin
                        if (r_cnt == CNT_LAST) begin
                           r_av  <= 1'b1;
                           r_idx <= target_index;
                        end else begin
                           r_cnt <= r_cnt + 1'b1;
                        end
                     end
                  end
               end
               S_DEAD: begin
                  r_state <= S_DEAD;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign pos_x        = r_pos_x;
   assign pos_y        = r_pos_y;
   assign hp           = r_hp;
   assign state        = r_state;
   assign attack_valid = r_av;
   assign attack_index = r_idx;

endmodule

// File: tb/tb_troop_unit.sv
// Self-checking bench for troop_unit: directed scenarios with constant
// expectations plus a randomized run against an integer reference model.
module tb_troop_unit;
   localparam int HP_MAX = 20, SPEED = 2, MOVE_DIV = 2, ATK_PERIOD = 60;
   localparam int NUM_SRC = 5, DMG_W = 3, TOL_X = 6, TOL_Y = 2;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic reset, frame_tick, idle, deploy_req, attack_ack;
   logic [9:0] deploy_x, deploy_y, target_x, target_y;
   logic [2:0] target_index;
   logic [14:0] dmg_in;
   logic [9:0] pos_x, pos_y, s5_pos_x, s5_pos_y;
   logic [4:0] hp, s5_hp;
   logic [1:0] state, s5_state;
   logic attack_valid, s5_attack_valid;
   logic [2:0] attack_index, s5_attack_index;

   int n_checks = 0;
   int n_fail = 0;

   // reference model state (plain integers)
   int m_state = 0, m_x = 0, m_y = 0, m_hp = 0, m_cnt = 0, m_div = 0, m_av = 0, m_idx = 0;

   troop_unit #(.HP_MAX(20), .SPEED(2), .MOVE_DIV(2), .ATK_PERIOD(60),
                .NUM_SRC(5), .DMG_W(3), .TOL_X(6), .TOL_Y(2)) dut (
      .Clk(Clk), .reset(reset), .frame_tick(frame_tick), .idle(idle),
      .deploy_req(deploy_req), .deploy_x(deploy_x), .deploy_y(deploy_y),
      .target_x(target_x), .target_y(target_y), .target_index(target_index),
      .dmg_in(dmg_in), .attack_ack(attack_ack), .pos_x(pos_x), .pos_y(pos_y),
      .hp(hp), .state(state), .attack_valid(attack_valid), .attack_index(attack_index));

   troop_unit #(.SPEED(5)) dut5 (
      .Clk(Clk), .reset(reset), .frame_tick(frame_tick), .idle(idle),
      .deploy_req(deploy_req), .deploy_x(deploy_x), .deploy_y(deploy_y),
      .target_x(target_x), .target_y(target_y), .target_index(target_index),
      .dmg_in(dmg_in), .attack_ack(attack_ack), .pos_x(s5_pos_x), .pos_y(s5_pos_y),
      .hp(s5_hp), .state(s5_state), .attack_valid(s5_attack_valid),
      .attack_index(s5_attack_index));

   function automatic int iabs(int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int approach(int p, int t, int sp);
      int d = t - p;
      if (d > sp) return p + sp;
      if (d < -sp) return p - sp;
      return t;
   endfunction

   function automatic logic [9:0] clamp10(int v);
      if (v < 0) return 10'd0;
      if (v > 1023) return 10'd1023;
      return 10'(v);
   endfunction

   // Reference behaviour evaluated at each rising edge from the current inputs.
   task automatic model_step();
      int dmg, tx, ty;
      int ackd;
      tx = target_x;
      ty = target_y;
      if (reset || idle) begin
         m_state = 0; m_x = 0; m_y = 0; m_hp = 0; m_cnt = 0; m_div = 0; m_av = 0; m_idx = 0;
         return;
      end
      ackd = (m_av != 0 && attack_ack) ? 1 : 0;
      if (ackd != 0) begin m_av = 0; m_cnt = 0; end
      if (!frame_tick) return;
      dmg = 0;
      for (int i = 0; i < NUM_SRC; i++) dmg += int'(dmg_in[i*DMG_W +: DMG_W]);
      if (m_state == 0) begin
         if (deploy_req) begin
            m_x = deploy_x; m_y = deploy_y; m_hp = HP_MAX; m_state = 1; m_div = 0; m_cnt = 0;
         end
      end else if (m_state == 1 || m_state == 2) begin
         if (dmg >= m_hp) begin
            m_hp = 0; m_state = 3; m_av = 0;
            return;
         end
         m_hp -= dmg;
         if (m_state == 1) begin
            m_div++;
            if (m_div == MOVE_DIV) begin
               m_div = 0;
               m_x = approach(m_x, tx, SPEED);
               m_y = approach(m_y, ty, SPEED);
            end
            if (iabs(m_x - tx) <= TOL_X && iabs(m_y - ty) <= TOL_Y) begin
               m_state = 2; m_cnt = 0;
            end
         end else if (!(iabs(m_x - tx) <= TOL_X && iabs(m_y - ty) <= TOL_Y)) begin
            m_state = 1; m_div = 0; m_cnt = 0; m_av = 0;
         end else if (ackd == 0 && m_av == 0) begin
            if (m_cnt == ATK_PERIOD - 1) begin m_av = 1; m_idx = target_index; end
            else m_cnt++;
         end
      end
   endtask

   task automatic cycle();
      @(posedge Clk);
      model_step();
      @(negedge Clk);
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      cycle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      n_checks++;
      if ({state, pos_x, pos_y, hp, attack_valid, attack_index} !== 31'd0) begin
         n_fail++;
         $display("FAIL reset: st=%0d x=%0d y=%0d hp=%0d av=%0d idx=%0d, want all 0",
                  state, pos_x, pos_y, hp, attack_valid, attack_index);
      end
   endtask

   task automatic test_march_engage();
      int ex[4], es[4];
      ex = '{100, 102, 102, 104};
      es = '{1, 1, 1, 2};
      deploy_x = 10'd100; deploy_y = 10'd100; target_x = 10'd110; target_y = 10'd100;
      target_index = 3'd5;
      deploy_req = 1'b1;
      tick();
      deploy_req = 1'b0;
      n_checks++;
      if (state !== 2'd1 || pos_x !== 10'd100 || hp !== 5'd20) begin
         n_fail++;
         $display("FAIL deploy: st=%0d x=%0d hp=%0d, want st=1 x=100 hp=20", state, pos_x, hp);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++;
         if (pos_x !== 10'(ex[k]) || state !== 2'(es[k])) begin
            n_fail++;
            $display("FAIL march step %0d: x=%0d st=%0d, want x=%0d st=%0d", k, pos_x, state, ex[k], es[k]);
         end
      end
   endtask

   task automatic test_attack_timing();
      int rise, held;
      rise = 0;
      for (int k = 1; k <= 100 && rise == 0; k++) begin
         tick();
         if (attack_valid === 1'b1) rise = k;
      end
      n_checks++;
      if (rise != 60 || attack_index !== 3'd5) begin
         n_fail++;
         $display("FAIL first attack: rise tick=%0d idx=%0d, want 60 idx=5", rise, attack_index);
      end
      target_index = 3'd2;
      held = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (attack_valid === 1'b1 && attack_index === 3'd5) held++;
      end
      n_checks++;
      if (held != 10) begin
         n_fail++;
         $display("FAIL attack hold: stable for %0d ticks, want 10", held);
      end
      attack_ack = 1'b1;
      cycle();
      attack_ack = 1'b0;
      n_checks++;
      if (attack_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ack drop: av=%0d, want 0", attack_valid);
      end
      rise = 0;
      for (int k = 1; k <= 100 && rise == 0; k++) begin
         tick();
         if (attack_valid === 1'b1) rise = k;
      end
      n_checks++;
      if (rise != 60 || attack_index !== 3'd2) begin
         n_fail++;
         $display("FAIL second attack: rise tick=%0d idx=%0d, want 60 idx=2", rise, attack_index);
      end
   endtask

   task automatic test_target_jump();
      int rise;
      target_x = 10'd160;
      tick();
      n_checks++;
      if (state !== 2'd1 || attack_valid !== 1'b0 || pos_x !== 10'd104) begin
         n_fail++;
         $display("FAIL target jump: st=%0d av=%0d x=%0d, want st=1 av=0 x=104", state, attack_valid, pos_x);
      end
      target_x = 10'd110;
      tick();
      rise = 0;
      for (int k = 1; k <= 100 && rise == 0; k++) begin
         tick();
         if (attack_valid === 1'b1) rise = k;
      end
      n_checks++;
      if (rise != 60) begin
         n_fail++;
         $display("FAIL re-engage attack: rise tick=%0d, want 60", rise);
      end
   endtask

   task automatic test_reset_midattack();
      reset = 1'b1; attack_ack = 1'b1; frame_tick = 1'b1;
      cycle();
      reset = 1'b0; attack_ack = 1'b0; frame_tick = 1'b0;
      n_checks++;
      if ({state, pos_x, pos_y, hp, attack_valid, attack_index} !== 31'd0 ||
          s5_state !== 2'd0 || s5_attack_index !== 3'd0) begin
         n_fail++;
         $display("FAIL reset mid-attack: st=%0d x=%0d hp=%0d av=%0d idx=%0d, want all 0",
                  state, pos_x, hp, attack_valid, attack_index);
      end
   endtask

   task automatic test_overkill();
      deploy_x = 10'd100; deploy_y = 10'd100; target_x = 10'd200; target_y = 10'd100;
      deploy_req = 1'b1;
      tick();
      deploy_req = 1'b0;
      dmg_in = {3'd3, 3'd0, 3'd0, 3'd2, 3'd1};
      tick();
      n_checks++;
      if (hp !== 5'd14 || state !== 2'd1 || pos_x !== 10'd100) begin
         n_fail++;
         $display("FAIL partial damage: hp=%0d st=%0d x=%0d, want hp=14 st=1 x=100", hp, state, pos_x);
      end
      dmg_in = 15'h7fff;
      tick();
      dmg_in = 15'd0;
      n_checks++;
      if (hp !== 5'd0 || state !== 2'd3 || attack_valid !== 1'b0 || pos_x !== 10'd100) begin
         n_fail++;
         $display("FAIL overkill: hp=%0d st=%0d av=%0d x=%0d, want hp=0 st=3 av=0 x=100",
                  hp, state, attack_valid, pos_x);
      end
      deploy_req = 1'b1;
      tick();
      deploy_req = 1'b0;
      n_checks++;
      if (state !== 2'd3 || pos_x !== 10'd100 || hp !== 5'd0) begin
         n_fail++;
         $display("FAIL deploy while dead: st=%0d x=%0d hp=%0d, want st=3 x=100 hp=0", state, pos_x, hp);
      end
   endtask

   task automatic test_idle_priority();
      idle = 1'b1;
      cycle();
      idle = 1'b0;
      n_checks++;
      if (state !== 2'd0 || pos_x !== 10'd0 || hp !== 5'd0) begin
         n_fail++;
         $display("FAIL idle from dead: st=%0d x=%0d hp=%0d, want 0 0 0", state, pos_x, hp);
      end
      deploy_x = 10'd300; deploy_y = 10'd300; target_x = 10'd400; target_y = 10'd300;
      deploy_req = 1'b1;
      tick();
      idle = 1'b1; frame_tick = 1'b1;
      cycle();
      idle = 1'b0; frame_tick = 1'b0; deploy_req = 1'b0;
      n_checks++;
      if (state !== 2'd0 || pos_x !== 10'd0 || pos_y !== 10'd0 || hp !== 5'd0) begin
         n_fail++;
         $display("FAIL idle+deploy: st=%0d x=%0d y=%0d hp=%0d, want 0 0 0 0", state, pos_x, pos_y, hp);
      end
   endtask

   task automatic test_edges();
      deploy_x = 10'd1; deploy_y = 10'd500; target_x = 10'd0; target_y = 10'd520;
      deploy_req = 1'b1;
      tick();
      deploy_req = 1'b0;
      tick();
      tick();
      n_checks++;
      if (pos_x !== 10'd0 || pos_y !== 10'd502 || state !== 2'd1) begin
         n_fail++;
         $display("FAIL low edge: x=%0d y=%0d st=%0d, want 0 502 1", pos_x, pos_y, state);
      end
      idle = 1'b1;
      cycle();
      idle = 1'b0;
      deploy_x = 10'd20; deploy_y = 10'd1022; target_x = 10'd40; target_y = 10'd1023;
      deploy_req = 1'b1;
      tick();
      deploy_req = 1'b0;
      tick();
      tick();
      n_checks++;
      if (pos_x !== 10'd22 || pos_y !== 10'd1023) begin
         n_fail++;
         $display("FAIL high edge: x=%0d y=%0d, want 22 1023", pos_x, pos_y);
      end
   endtask

   task automatic test_speed5();
      idle = 1'b1;
      cycle();
      idle = 1'b0;
      deploy_x = 10'd100; deploy_y = 10'd100; target_x = 10'd103; target_y = 10'd97;
      deploy_req = 1'b1;
      tick();
      deploy_req = 1'b0;
      tick();
      tick();
      n_checks++;
      if (s5_pos_x !== 10'd103 || s5_pos_y !== 10'd97 || s5_state !== 2'd2 ||
          s5_hp !== 5'd20 || s5_attack_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL speed5: x=%0d y=%0d st=%0d hp=%0d av=%0d, want 103 97 2 20 0",
                  s5_pos_x, s5_pos_y, s5_state, s5_hp, s5_attack_valid);
      end
      n_checks++;
      if (pos_x !== 10'd102 || pos_y !== 10'd98 || state !== 2'd2) begin
         n_fail++;
         $display("FAIL speed2 partial: x=%0d y=%0d st=%0d, want 102 98 2", pos_x, pos_y, state);
      end
   endtask

   task automatic test_random();
      logic [27:0] got, want;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         frame_tick = ($urandom_range(0, 2) == 0);
         idle       = ($urandom_range(0, 299) == 0);
         reset      = ($urandom_range(0, 999) == 0);
         deploy_req = ($urandom_range(0, 3) == 0);
         attack_ack = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 399) == 0) begin
            target_x = clamp10(m_x + int'($urandom_range(0, 60)) - 30);
            target_y = clamp10(m_y + int'($urandom_range(0, 12)) - 6);
            target_index = 3'($urandom_range(0, 7));
         end
         deploy_x = clamp10(int'(target_x) + int'($urandom_range(0, 50)) - 25);
         deploy_y = clamp10(int'(target_y) + int'($urandom_range(0, 10)) - 5);
         if ($urandom_range(0, 299) == 0) dmg_in = 15'($urandom);
         else if ($urandom_range(0, 39) == 0)
            dmg_in = 15'($urandom_range(0, 7)) << (3 * $urandom_range(0, 4));
         else dmg_in = 15'd0;
         cycle();
         got  = {state, pos_x, pos_y, hp, attack_valid};
         want = {m_state[1:0], m_x[9:0], m_y[9:0], m_hp[4:0], m_av[0]};
         n_checks++;
         if (got !== want) begin
            n_fail++;
            if (n_fail < 30)
               $display("FAIL random cycle %0d: st=%0d x=%0d y=%0d hp=%0d av=%0d, want st=%0d x=%0d y=%0d hp=%0d av=%0d",
                        c, state, pos_x, pos_y, hp, attack_valid, m_state, m_x, m_y, m_hp, m_av);
         end
         if (m_av != 0) begin
            n_checks++;
            if (attack_index !== m_idx[2:0]) begin
               n_fail++;
               if (n_fail < 30)
                  $display("FAIL random index cycle %0d: idx=%0d, want %0d", c, attack_index, m_idx);
            end
         end
      end
      reset = 1'b0; idle = 1'b0; deploy_req = 1'b0; attack_ack = 1'b0; frame_tick = 1'b0;
      dmg_in = 15'd0;
   endtask

   initial begin
      reset = 1'b1; frame_tick = 1'b0; idle = 1'b0; deploy_req = 1'b0; attack_ack = 1'b0;
      deploy_x = 10'd0; deploy_y = 10'd0; target_x = 10'd0; target_y = 10'd0;
      target_index = 3'd0; dmg_in = 15'd0;
      test_reset();
      test_march_engage();
      test_attack_timing();
      test_target_jump();
      test_reset_midattack();
      test_overkill();
      test_idle_priority();
      test_edges();
      test_speed5();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
